// File: rtl/div_earlyterm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_earlyterm: radix-2^K restoring divider with leading-zero skip          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_earlyterm #(
  parameter int XLEN         = 64,
  parameter int BITSPERCYCLE = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic            Signed,
  input  logic            W64,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] D,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Quot,
  output logic [XLEN-1:0] Rem
);

  localparam int c_K    = BITSPERCYCLE;
  localparam int c_LOGK = $clog2(BITSPERCYCLE);
  localparam int c_CNTW = $clog2(XLEN / BITSPERCYCLE + 1);
  localparam int c_LZW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_inReady, r_outValid;
  logic              r_signed, r_w64;
  logic [XLEN-1:0]   r_x, r_d;
  logic              r_div0, r_negQ, r_negR;
  logic [XLEN-1:0]   r_dAbs, r_q, r_rem;
  logic [c_CNTW-1:0] r_cnt;

  logic              w_w64;
  logic [XLEN-1:0]   w_xExt, w_dExt, w_xAbs, w_dAbs, w_xPre;
  logic              w_sx, w_sd, w_div0;
  logic [c_LZW-1:0]  w_lz, w_lzN, w_skip, w_nBits, w_shAmt;
  logic [c_CNTW-1:0] w_iters;
  logic [XLEN-1:0]   w_q, w_rem;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_qRes, w_rRes;

  generate
    if (XLEN == 64) begin : g_w64
      assign w_w64 = W64;
    end else begin : g_nw64
      assign w_w64 = 1'b0;
    end
  endgenerate

  // Sign- or zero-extend the low 32 bits when w is set.
  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w,
                                           input logic sgn);
    logic [XLEN-1:0] res;
    res = v;
    if (w)
      for (int i = 32; i < XLEN; i++) res[i] = sgn & v[31];
    return res;
  endfunction

  assign w_xExt = wext(r_x, r_w64, r_signed);
  assign w_dExt = wext(r_d, r_w64, r_signed);
  assign w_sx   = r_signed & w_xExt[XLEN-1];
  assign w_sd   = r_signed & w_dExt[XLEN-1];
  assign w_xAbs = w_sx ? (~w_xExt + 1'b1) : w_xExt;
  assign w_dAbs = w_sd ? (~w_dExt + 1'b1) : w_dExt;
  assign w_div0 = r_w64 ? (r_d[31:0] == 32'd0) : (r_d == '0);

  always_comb begin
    w_lz = c_LZW'(XLEN);
    for (int i = 0; i < XLEN; i++)
      if (w_xAbs[i]) w_lz = c_LZW'(XLEN - 1 - i);
  end

  // W-type magnitudes live in the low 32 bits, so their upper zeros are not counted.
  assign w_lzN   = r_w64 ? (w_lz - c_LZW'(XLEN - 32)) : w_lz;
  assign w_skip  = w_lzN & ~c_LZW'(c_K - 1);
  assign w_nBits = r_w64 ? c_LZW'(32) : c_LZW'(XLEN);
  assign w_iters = c_CNTW'((w_nBits - w_skip) >> c_LOGK);
  assign w_shAmt = c_LZW'(XLEN) - w_nBits + w_skip;
  assign w_xPre  = w_xAbs << w_shAmt;

  // K restoring steps: dividend bits leave the top of r_q, quotient bits enter the bottom.
  always_comb begin
    w_q     = r_q;
    w_rem   = r_rem;
    w_trial = '0;
    for (int s = 0; s < c_K; s++) begin
      w_trial = {w_rem, w_q[XLEN-1]};
      if (w_trial >= {1'b0, r_dAbs}) begin
        w_trial = w_trial - {1'b0, r_dAbs};
        w_q     = {w_q[XLEN-2:0], 1'b1};
      end else begin
        w_q     = {w_q[XLEN-2:0], 1'b0};
      end
      w_rem = w_trial[XLEN-1:0];
    end
  end

  always_comb begin
    if (r_div0) begin
      w_qRes = '1;
      w_rRes = r_x;
    end else begin
      w_qRes = r_negQ ? (~r_q + 1'b1) : r_q;
      w_rRes = r_negR ? (~r_rem + 1'b1) : r_rem;
    end
  end

  assign Quot     = (r_state == DONE) ? wext(w_qRes, r_w64, 1'b1) : '0;
  assign Rem      = (r_state == DONE) ? wext(w_rRes, r_w64, 1'b1) : '0;
  assign InReady  = r_inReady;
  assign OutValid = r_outValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_signed   <= 1'b0;
      r_w64      <= 1'b0;
      r_x        <= '0;
      r_d        <= '0;
      r_div0     <= 1'b0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_dAbs     <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
    end else if (Flush) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid && r_inReady) begin
            r_signed  <= Signed;
            r_w64     <= w_w64;
            r_x       <= X;
            r_d       <= D;
            r_inReady <= 1'b0;
            r_state   <= PREP;
          end
        end
        PREP: begin
          r_div0 <= w_div0;
          r_negQ <= w_sx ^ w_sd;
          r_negR <= w_sx;
          r_dAbs <= w_dAbs;
          r_q    <= w_xPre;
          r_rem  <= '0;
          r_cnt  <= w_iters;
          if (w_div0 || (w_iters == '0)) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_q   <= w_q;
          r_rem <= w_rem;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNTW'(1)) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_earlyterm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_earlyterm: randomized check of div_earlyterm against an arithmetic  |
// | reference. Revision: 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_div_earlyterm;

  localparam int XLEN = 64;
  localparam int K    = 2;

  logic            clk, reset, Flush, InValid, InReady, Signed, W64, OutValid, OutReady;
  logic [XLEN-1:0] X, D, Quot, Rem;

  int nChecks = 0;
  int nMiss   = 0;

  div_earlyterm #(.XLEN(XLEN), .BITSPERCYCLE(K)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Signed(Signed), .W64(W64), .X(X), .D(D), .OutValid(OutValid),
    .OutReady(OutReady), .Quot(Quot), .Rem(Rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // Results from magnitudes with plain / and %; latency from the dividend's bit length.
  task automatic model(input logic sg, input logic w, input logic [63:0] x, input logic [63:0] d,
                       output logic [63:0] eq, output logic [63:0] er, output int lat);
    logic [63:0] xe, de, ax, ad, t;
    logic        sx, sd;
    int          nb;
    xe = w ? (sg ? sext32(x) : {32'b0, x[31:0]}) : x;
    de = w ? (sg ? sext32(d) : {32'b0, d[31:0]}) : d;
    if (w ? (d[31:0] == 32'd0) : (d == 64'd0)) begin
      eq  = '1;
      er  = w ? sext32(x) : x;
      lat = 2;
    end else begin
      sx = sg && xe[63];
      sd = sg && de[63];
      ax = sx ? -xe : xe;
      ad = sd ? -de : de;
      eq = ax / ad;
      er = ax % ad;
      if (sx ^ sd) eq = -eq;
      if (sx) er = -er;
      if (w) begin
        eq = sext32(eq);
        er = sext32(er);
      end
      nb = 0;
      t  = ax;
      while (t != 64'd0) begin
        t = t >> 1;
        nb++;
      end
      lat = (nb == 0) ? 2 : (nb + K - 1) / K + 2;
    end
  endtask

  // Latency counts clock edges starting with (and including) the acceptance edge.
  task automatic runOp(input logic sg, input logic w, input logic [63:0] x, input logic [63:0] d,
                       input int hold, input string name);
    logic [63:0] eq, er;
    int          lat, cnt;
    model(sg, w, x, d, eq, er, lat);
    @(negedge clk);
    chk({name, " inready"}, 64'(InReady), 64'd1);
    Signed   = sg;
    W64      = w;
    X        = x;
    D        = d;
    InValid  = 1'b1;
    OutReady = 1'b0;
    cnt      = 0;
    do begin
      @(posedge clk);
      #1;
      InValid = 1'b0;
      cnt++;
    end while (!OutValid && cnt < 100);
    chk({name, " latency"}, 64'(cnt), 64'(lat));
    chk({name, " quot"}, Quot, eq);
    chk({name, " rem"}, Rem, er);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({name, " held"}, {Quot[31:0] ^ Rem[31:0], 31'd0, OutValid}, {eq[31:0] ^ er[31:0], 32'd1});
    end
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    OutReady = 1'b0;
    chk({name, " drop outvalid"}, 64'(OutValid), 64'd0);
  endtask

  task automatic startLong();
    @(negedge clk);
    Signed  = 1'b0;
    W64     = 1'b0;
    X       = '1;
    D       = 64'd3;
    InValid = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [63:0] rx, rd;
    int          sel;
    logic        seen;
    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Signed = 1'b0; W64 = 1'b0; X = '0; D = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset inready", 64'(InReady), 64'd1);
    chk("reset outvalid", 64'(OutValid), 64'd0);
    chk("reset quot", Quot, 64'd0);
    chk("reset rem", Rem, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runOp(1'b0, 1'b0, 64'd100, 64'd7, 5, "divu 100/7");
    runOp(1'b1, 1'b0, -64'sd7, 64'd2, 0, "div -7/2");
    runOp(1'b0, 1'b0, 64'd5, 64'd0, 0, "divu 5/0");
    runOp(1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "div ovf");
    runOp(1'b1, 1'b1, 64'h0000_0000_8000_0000, '1, 0, "divw ovf");
    runOp(1'b1, 1'b0, 64'd0, 64'd9, 0, "div zero x");
    runOp(1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd3, 1, "divw zero low x");

    // Flush during the third BUSY cycle.
    startLong();
    #1;
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    chk("flush inready", 64'(InReady), 64'd1);
    chk("flush outvalid", 64'(OutValid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (OutValid) seen = 1'b1;
    end
    chk("flush no result", 64'(seen), 64'd0);

    // Flush wins over a simultaneous InValid in IDLE.
    @(negedge clk);
    Flush = 1'b1;
    InValid = 1'b1;
    X = 64'd10;
    D = 64'd0;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    InValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush over invalid", {63'd0, InReady}, 64'd1);

    // Asynchronous reset in the middle of BUSY.
    startLong();
    #1;
    reset = 1'b1;
    #1;
    chk("midreset inready", 64'(InReady), 64'd1);
    chk("midreset outvalid", 64'(OutValid), 64'd0);
    chk("midreset quot", Quot, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runOp(1'b0, 1'b0, 64'd100, 64'd7, 0, "after reset");

    for (int n = 0; n < 300; n++) begin
      rx  = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) rx = ~rx;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) rd = 64'd0;
      else if (sel == 1) rd = '1;
      else begin
        rd = {$urandom(), $urandom()} >> $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) rd = ~rd;
      end
      runOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rx, rd,
            int'($urandom_range(0, 2)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
    $finish;
  end

endmodule
`default_nettype wire
